// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and pixel-output engine.
// A prescaler produces the pixel tick. Horizontal and vertical counters
// (stage p0) present the current coordinate to the pixel source. Sync and
// blanked RGB are registered one tick later (stage p1) and drive the pins.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 1,
  parameter int CTR_W    = 11
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iEnable,
  input  logic [3*COLOR_W-1:0] iRGB,
  output logic [CTR_W-1:0]     oPixelX,
  output logic [CTR_W-1:0]     oPixelY,
  output logic                 oActive,
  output logic                 oTick,
  output logic                 oLineStart,
  output logic                 oFrameStart,
  output logic [7:0]           oFrameCount,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic [COLOR_W-1:0]   VGA_RED,
  output logic [COLOR_W-1:0]   VGA_GREEN,
  output logic [COLOR_W-1:0]   VGA_BLUE
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [CTR_W-1:0] H_LAST   = CTR_W'(H_TOTAL - 1);
  localparam logic [CTR_W-1:0] V_LAST   = CTR_W'(V_TOTAL - 1);
  localparam logic [CTR_W-1:0] H_VIS    = CTR_W'(H_ACTIVE);
  localparam logic [CTR_W-1:0] V_VIS    = CTR_W'(V_ACTIVE);
  localparam logic [CTR_W-1:0] HS_START = CTR_W'(H_ACTIVE + H_FP);
  localparam logic [CTR_W-1:0] HS_END   = CTR_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CTR_W-1:0] VS_START = CTR_W'(V_ACTIVE + V_FP);
  localparam logic [CTR_W-1:0] VS_END   = CTR_W'(V_ACTIVE + V_FP + V_SYNC);

  // Half-open window test used for both sync pulses.
  function automatic logic in_window(input logic [CTR_W-1:0] c,
                                     input logic [CTR_W-1:0] lo,
                                     input logic [CTR_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  // Map "inside sync pulse" onto the configured pin polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

  // Colour is forced to black anywhere outside the visible area.
  function automatic logic [3*COLOR_W-1:0] blank_rgb(input logic act,
                                                     input logic [3*COLOR_W-1:0] rgb);
    return act ? rgb : '0;
  endfunction

  logic [PS_W-1:0]      prescale_p0;
  logic [PS_W-1:0]      prescale_nxt;
  logic                 vld_p0;          // pixel tick: coordinate is captured this cycle
  logic                 advance;
  logic [CTR_W-1:0]     hcnt_p0;
  logic [CTR_W-1:0]     vcnt_p0;
  logic                 h_wrap;
  logic                 v_wrap;
  logic                 act_p0;
  logic                 line_start_p0;
  logic                 frame_start_p0;
  logic [7:0]           frame_cnt;
  logic                 hs_p1;
  logic                 vs_p1;
  logic [3*COLOR_W-1:0] rgb_p1;

  // Next prescaler value: wraps after CLK_DIV-1 (stays 0 when CLK_DIV=1).
  always_comb begin
    prescale_nxt = (prescale_p0 == PS_LAST) ? '0 : prescale_p0 + PS_W'(1);
  end

  assign advance = vld_p0 & iEnable;
  assign h_wrap  = (hcnt_p0 == H_LAST);
  assign v_wrap  = (vcnt_p0 == V_LAST);
  assign act_p0  = (hcnt_p0 < H_VIS) && (vcnt_p0 < V_VIS);

  // Stage p0: prescaler and registered tick, cleared while disabled.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prescale_p0 <= '0;
      vld_p0      <= 1'b0;
    end else if (!iEnable) begin
      prescale_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      prescale_p0 <= prescale_nxt;
      vld_p0      <= (prescale_nxt == PS_LAST);
    end
  end

  // Stage p0: coordinate counters, wrap strobes and frame counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hcnt_p0        <= '0;
      vcnt_p0        <= '0;
      line_start_p0  <= 1'b0;
      frame_start_p0 <= 1'b0;
      frame_cnt      <= 8'd0;
    end else if (!iEnable) begin
      hcnt_p0        <= '0;
      vcnt_p0        <= '0;
      line_start_p0  <= 1'b0;
      frame_start_p0 <= 1'b0;
    end else begin
      line_start_p0  <= advance & h_wrap;
      frame_start_p0 <= advance & h_wrap & v_wrap;
      if (advance) begin
        if (h_wrap) begin
          hcnt_p0 <= '0;
          if (v_wrap) begin
            vcnt_p0   <= '0;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            vcnt_p0 <= vcnt_p0 + CTR_W'(1);
          end
        end else begin
          hcnt_p0 <= hcnt_p0 + CTR_W'(1);
        end
      end
    end
  end

  // ---- stage p0 -> p1 boundary: pins sampled from pre-increment coordinate ----
  // Stage p1: sync and blanked colour registered on each tick.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hs_p1  <= ~HS_POL;
      vs_p1  <= ~VS_POL;
      rgb_p1 <= '0;
    end else if (!iEnable) begin
      hs_p1  <= ~HS_POL;
      vs_p1  <= ~VS_POL;
      rgb_p1 <= '0;
    end else if (advance) begin
      hs_p1  <= sync_level(in_window(hcnt_p0, HS_START, HS_END), HS_POL);
      vs_p1  <= sync_level(in_window(vcnt_p0, VS_START, VS_END), VS_POL);
      rgb_p1 <= blank_rgb(act_p0, iRGB);
    end
  end

  assign oPixelX     = hcnt_p0;
  assign oPixelY     = vcnt_p0;
  assign oActive     = act_p0;
  assign oTick       = vld_p0;
  assign oLineStart  = line_start_p0;
  assign oFrameStart = frame_start_p0;
  assign oFrameCount = frame_cnt;
  assign VGA_HS      = hs_p1;
  assign VGA_VS      = vs_p1;
  assign VGA_RED     = rgb_p1[3*COLOR_W-1 -: COLOR_W];
  assign VGA_GREEN   = rgb_p1[2*COLOR_W-1 -: COLOR_W];
  assign VGA_BLUE    = rgb_p1[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-geometry instance checked every clock
// against a tick-count model with a pin scoreboard, plus a default
// 640x480 instance with positive HS checked on line timing.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HSY = 3, HB = 1;
  localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
  localparam int DIV = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } pins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic [2:0]  rgb_in;
  logic [10:0] px, py;
  logic        act, tick, ls, fs, hs, vs, r, g, b;
  logic [7:0]  fc;

  logic        rst2_n, en2;
  logic [2:0]  rgb2_in;
  logic [10:0] px2, py2;
  logic        act2, tick2, ls2, fs2, hs2, vs2, r2, g2, b2;
  logic [7:0]  fc2;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .CLK_DIV(DIV), .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(1), .CTR_W(11)
  ) dut (
    .Clock(clk), .Reset(rst_n), .iEnable(en), .iRGB(rgb_in),
    .oPixelX(px), .oPixelY(py), .oActive(act), .oTick(tick),
    .oLineStart(ls), .oFrameStart(fs), .oFrameCount(fc),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_RED(r), .VGA_GREEN(g), .VGA_BLUE(b)
  );

  vga_timing_gen #(.HS_POL(1'b1)) dut_hd (
    .Clock(clk), .Reset(rst2_n), .iEnable(en2), .iRGB(rgb2_in),
    .oPixelX(px2), .oPixelY(py2), .oActive(act2), .oTick(tick2),
    .oLineStart(ls2), .oFrameStart(fs2), .oFrameCount(fc2),
    .VGA_HS(hs2), .VGA_VS(vs2), .VGA_RED(r2), .VGA_GREEN(g2), .VGA_BLUE(b2)
  );

  int    checks = 0;
  int    failures = 0;
  pins_t sb_q[$];
  pins_t cur;
  int    n = 0;
  int    fc_m = 0;
  int    cyc = 0;
  int    last_ls = -1, last_fs = -1;
  int    hs_low = 0, vs_low = 0, rgb_on = 0, fs_seen = 0;
  bit    agg_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected small-DUT state derived from enabled edges since last clear.
  task automatic check_dut1();
    int t, p, h, v;
    t = n / DIV;
    p = t % FT;
    h = p % HT;
    v = p / HT;
    chk("pixel_x", 32'(px), 32'(h));
    chk("pixel_y", 32'(py), 32'(v));
    chk("active", 32'(act), 32'((h < HA) && (v < VA)));
    chk("tick", 32'(tick), 32'(n % DIV == DIV - 1));
    chk("line_start", 32'(ls), 32'((n > 0) && (n % DIV == 0) && (h == 0)));
    chk("frame_start", 32'(fs), 32'((n > 0) && (n % DIV == 0) && (p == 0)));
    chk("frame_count", 32'(fc), 32'(fc_m));
    chk("vga_hs", 32'(hs), 32'(cur.hs));
    chk("vga_vs", 32'(vs), 32'(cur.vs));
    chk("vga_rgb", 32'({r, g, b}), 32'(cur.rgb));
  endtask

  task automatic cycle();
    int t, p, h, v;
    pins_t e;
    if (rst_n && en && (n % DIV == DIV - 1)) begin
      t = n / DIV;
      p = t % FT;
      h = p % HT;
      v = p / HT;
      e.hs  = !((h >= HA + HF) && (h < HA + HF + HSY));
      e.vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
      e.rgb = ((h < HA) && (v < VA)) ? rgb_in : 3'b000;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (!en) begin
        n = 0;
        cur = '{hs: 1'b1, vs: 1'b1, rgb: 3'b000};
        last_ls = -1;
        last_fs = -1;
      end else begin
        n++;
        if (n % DIV == 0) begin
          chk("sb_depth", 32'(sb_q.size()), 32'd1);
          if (sb_q.size() > 0) cur = sb_q.pop_front();
          if ((n / DIV) % FT == 0) fc_m = (fc_m + 1) % 256;
        end
      end
    end
    if (ls) begin
      if (last_ls >= 0) begin
        chk("line_period_clks", 32'(cyc - last_ls), 32'd28);
        chk("hs_low_clks", 32'(hs_low), 32'd6);
      end
      last_ls = cyc;
      hs_low = 0;
    end
    if (fs) begin
      fs_seen++;
      if (last_fs >= 0) begin
        chk("frame_period_clks", 32'(cyc - last_fs), 32'd224);
        chk("vs_low_clks", 32'(vs_low), 32'd56);
        if (agg_on) chk("rgb_on_clks", 32'(rgb_on), 32'd64);
      end
      last_fs = cyc;
      vs_low = 0;
      rgb_on = 0;
    end
    if (hs == 1'b0) hs_low++;
    if (vs == 1'b0) vs_low++;
    if ({r, g, b} == 3'b111) rgb_on++;
    check_dut1();
  endtask

  initial begin
    int guard;
    bit timeout;
    int last_ls2, hs2_high;
    logic prev_hs2;

    cur = '{hs: 1'b1, vs: 1'b1, rgb: 3'b000};
    rst_n = 1'b0; en = 1'b0; rgb_in = 3'b111;
    rst2_n = 1'b0; en2 = 1'b0; rgb2_in = 3'b101;

    // Reset held for 5 clocks
    repeat (5) cycle();
    chk("reset_hs", 32'(hs), 32'd1);
    chk("reset_fc", 32'(fc), 32'd0);

    // Run 2 frames, then a third for frame-aggregate checks
    rst_n = 1'b1; en = 1'b1; agg_on = 1'b1;
    repeat (2 * 2 * FT) cycle();
    chk("frame_count_after_2", 32'(fc), 32'd2);
    repeat (2 * FT + 4) cycle();
    chk("frame_starts_seen", 32'(fs_seen), 32'd3);

    // Disable at (5,2) for 10 clocks
    timeout = 1'b1;
    for (guard = 0; guard < 400; guard++) begin
      if (((n / DIV) % FT) == 2 * HT + 5) begin
        timeout = 1'b0;
        break;
      end
      cycle();
    end
    chk("reach_5_2_timeout", 32'(timeout), 32'd0);
    chk("at_x5", 32'(px), 32'd5);
    chk("at_y2", 32'(py), 32'd2);
    en = 1'b0;
    repeat (10) cycle();
    chk("dis_x", 32'(px), 32'd0);
    chk("dis_y", 32'(py), 32'd0);
    chk("dis_hs", 32'(hs), 32'd1);
    chk("dis_vs", 32'(vs), 32'd1);
    chk("dis_rgb", 32'({r, g, b}), 32'd0);
    chk("dis_fc_hold", 32'(fc), 32'd3);

    // Re-enable: no frame start until the natural wrap
    en = 1'b1;
    fs_seen = 0;
    repeat (2 * FT - 10) cycle();
    chk("no_spurious_fs", 32'(fs_seen), 32'd0);
    repeat (20) cycle();
    chk("natural_fs_after_reenable", 32'(fs_seen), 32'd1);
    chk("fc_after_reenable", 32'(fc), 32'd4);

    // Async reset between edges mid-frame
    repeat (50) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x", 32'(px), 32'd0);
    chk("arst_y", 32'(py), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_ls", 32'(ls), 32'd0);
    chk("arst_fs", 32'(fs), 32'd0);
    chk("arst_fc", 32'(fc), 32'd0);
    chk("arst_hs", 32'(hs), 32'd1);
    chk("arst_vs", 32'(vs), 32'd1);
    chk("arst_rgb", 32'({r, g, b}), 32'd0);
    n = 0; fc_m = 0; sb_q.delete();
    cur = '{hs: 1'b1, vs: 1'b1, rgb: 3'b000};
    last_ls = -1; last_fs = -1;
    repeat (3) cycle();
    rst_n = 1'b1;

    // Random colour after restart
    agg_on = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rgb_in = 3'($urandom_range(0, 7));
      cycle();
    end

    // Default geometry, HS_POL=1, small instance idle
    en = 1'b0;
    rgb_in = 3'b111;
    cycle();
    rst2_n = 1'b1; en2 = 1'b1;
    last_ls2 = -1; hs2_high = 0;
    prev_hs2 = hs2;
    for (int i = 0; i < 3300; i++) begin
      cycle();
      if (ls2) begin
        if (last_ls2 >= 0) begin
          chk("hd_line_period_clks", 32'(cyc - last_ls2), 32'd1600);
          chk("hd_hs_high_clks", 32'(hs2_high), 32'd192);
        end
        last_ls2 = cyc;
        hs2_high = 0;
      end
      if (hs2 == 1'b1) hs2_high++;
      if (hs2 == 1'b1 && prev_hs2 == 1'b0)
        chk("hd_hs_start_x", 32'(px2), 32'd657);
      prev_hs2 = hs2;
    end
    chk("hd_x_end", 32'(px2), 32'd50);
    chk("hd_y_end", 32'(py2), 32'd2);
    chk("hd_active_end", 32'(act2), 32'd1);
    chk("hd_tick_end", 32'(tick2), 32'd0);
    chk("hd_fs_end", 32'(fs2), 32'd0);
    chk("hd_fc_end", 32'(fc2), 32'd0);
    chk("hd_hs_end", 32'(hs2), 32'd0);
    chk("hd_vs_end", 32'(vs2), 32'd1);
    chk("hd_rgb_end", 32'({r2, g2, b2}), 32'd5);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing and pixel-output engine that replaces the fixed 640x480 sync logic. Geometry, sync polarity, pixel-clock divider and colour depth are all configurable.
- Generates HS/VS, exposes the current pixel coordinate to the pixel source, and registers blanked RGB to the pins.
- Sits between the frame/pattern logic of the MiniAlu top level and the board VGA connector.
- Adds over the previous generation: enable control, line/frame strobes and a frame counter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, horizontal sync width (pixel ticks)
- H_BP, 48, horizontal back porch (pixel ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, Clock cycles per pixel tick (>=1); 2 gives 25 MHz pixels from 50 MHz
- HS_POL, 0, asserted level of VGA_HS
- VS_POL, 0, asserted level of VGA_VS
- COLOR_W, 1, bits per colour channel
- CTR_W, 11, width of coordinate counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- iEnable  in  1  timing runs while high
- iRGB  in  3*COLOR_W  pixel colour for (oPixelX, oPixelY); packed {R,G,B}
- oPixelX  out  CTR_W  current horizontal count
- oPixelY  out  CTR_W  current vertical count
- oActive  out  1  high when oPixelX<H_ACTIVE and oPixelY<V_ACTIVE
- oTick  out  1  one-Clock pixel-tick strobe
- oLineStart  out  1  one-Clock pulse on the tick where oPixelX wraps to 0
- oFrameStart  out  1  one-Clock pulse on the tick where (oPixelX,oPixelY) becomes (0,0)
- oFrameCount  out  8  completed frames, wraps 255->0
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_RED, VGA_GREEN, VGA_BLUE  out  COLOR_W each  registered pixel colour

Behaviour:
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset low (async) values:
  - prescaler=0, hcnt=vcnt=0, oFrameCount=0
  - oTick/oLineStart/oFrameStart=0
  - VGA_HS=!HS_POL, VGA_VS=!VS_POL, RGB=0
- Prescaler:
  - Counts 0..CLK_DIV-1 while iEnable=1.
  - oTick=1 in the Clock cycle where prescaler==CLK_DIV-1.
  - CLK_DIV=1 gives oTick continuously high.
- Counter advance on each tick:
  - hcnt advances; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt at V_TOTAL-1 with hcnt wrap goes to 0 and oFrameCount increments.
  - Strobes are registered and fire in the cycle after the wrapping tick, aligned with the new counter values.
- Output pipeline, updated only on tick, from counter values before increment:
  - VGA_HS=HS_POL iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
  - VGA_VS=VS_POL iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC
  - RGB=iRGB if active, else 0
- Pipeline latency: exactly one pixel tick from coordinate presentation to pin.
- Pixel-source contract: the source must hold iRGB stable and valid for the displayed coordinate throughout the tick cycle.
- oPixelX, oPixelY and oActive are direct register/compare outputs with no extra latency.
- Sync is the same regardless of iRGB; RGB is forced to 0 in all blanking, including porches and sync.
- iEnable=0, synchronous:
  - Next Clock clears prescaler, hcnt and vcnt.
  - Sync outputs go inactive, RGB=0, strobes stay 0.
  - oFrameCount holds its value.
- Re-enable: the first tick presents (0,0). No oFrameStart pulse on re-enable; the first pulse is at the next natural wrap.
- Reset mid-frame: immediate return to reset values. Timing restarts at (0,0) on the first Clock after release if iEnable=1.
- Simultaneous H and V wrap is handled in the same tick; oLineStart and oFrameStart pulse together.

Test Plan:
1. Small geometry, HS_POL=VS_POL=0: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), CLK_DIV=2.
   - Reset low 5 cycles then high, iEnable=1.
   - Required: oTick every 2nd Clock.
   - Required: VGA_HS low for exactly 3 ticks per line, starting the tick after hcnt=10 is presented.
   - Required: line period 28 Clocks.
2. Same config, run 2 frames.
   - Required: VGA_VS low for 2 lines (56 Clocks) per frame; frame period 224 Clocks.
   - Required: oFrameStart pulses 224 Clocks apart; oFrameCount reads 2.
3. iRGB tied to 3'b111.
   - Required: RGB=111 only on the 32 visible ticks per frame (8x4); 0 in every porch/sync tick, including hcnt=8..13 and vcnt=4..7.
4. Deassert iEnable mid-line at hcnt=5, vcnt=2 for 10 Clocks, then reassert.
   - Required: counters read 0, syncs high, RGB=0 while disabled; oFrameCount unchanged.
   - Required: restart at (0,0) with no spurious oFrameStart.
5. Assert Reset low asynchronously between Clock edges mid-frame.
   - Required: outputs at reset values before the next edge; oFrameCount=0.
6. Defaults (640x480, CLK_DIV=2) with HS_POL=1.
   - Required: H_TOTAL=800 ticks (1600 Clocks) per line.
   - Required: VGA_HS high for 96 ticks starting at hcnt=656; V_TOTAL=525 lines.
